rf_dump_tx: RTL and testbench

//  Debug reader for the register file's debug read port (reg_sel/reg_data).
//  On a start pulse it sweeps x0..x(NREGS-1), samples each 32-bit value and

---
 rtl/rf_dump_tx_pkg.sv | 18 +
 rtl/rf_dump_ser.sv | 37 +++
 rtl/rf_dump_tx.sv | 133 +++++++++++++
 tb/tb_rf_dump_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_dump_tx_pkg.sv
// Shared types for the register-file debug dump: FSM state encoding and default frame sync byte.
// Imported by rf_dump_tx, rf_dump_ser and the bench frame checker.
package rf_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SEL   = 3'd2,
    ST_SEND  = 3'd3,
    ST_CKSUM = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'h5A;
  localparam int         IDX_W          = 5;
  localparam int         WORD_W         = 32;
  localparam int         BYTES_PER_REG  = WORD_W / 8;

endpackage

// File: rtl/rf_dump_ser.sv
// Word-to-byte serializer: loads a 32-bit word, presents it LSB byte first, shifts on each handshake.
// Output byte only changes on load or accepted handshake, so it is stable while stalled.
module rf_dump_ser
  import rf_dump_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              en,
  input  logic              ready,
  output logic [7:0]        data,
  output logic              last
);

  logic [WORD_W-1:0] shreg;
  logic [1:0]        byte_cnt;
  logic              fire;

  assign fire = en && ready;
  assign data = shreg[7:0];
  assign last = fire && (byte_cnt == 2'(BYTES_PER_REG - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shreg    <= word;
      byte_cnt <= '0;
    end else if (fire) begin
      shreg    <= {8'h00, shreg[WORD_W-1:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/rf_dump_tx.sv
// Register-file dump streamer: SYNC byte, then each register little-endian over valid/ready.
// Optional trailing XOR checksum byte when RF_DUMP_CKSUM_EN is defined.
module rf_dump_tx
  import rf_dump_tx_pkg::*;
#(
  parameter int         NREGS     = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  reg_sel,
  input  logic [WORD_W-1:0] reg_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] reg_sel_q;
  logic             done_nxt;
  logic             ser_load;
  logic             ser_en;
  logic [7:0]       ser_byte;
  logic             ser_last;
  logic             frame_start;

`ifdef RF_DUMP_CKSUM_EN
  logic [7:0] checksum;
`endif

  assign ser_load    = (state == ST_SEL);
  assign ser_en      = (state == ST_SEND);
  assign frame_start = (state == ST_IDLE) && (state_nxt == ST_SYNC);
  assign busy        = (state != ST_IDLE);
  // The register file is combinational, so reg_sel must show idx during SEL itself.
  assign reg_sel     = (state == ST_SEL) ? idx : reg_sel_q;

  rf_dump_ser u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .word  (reg_data),
    .en    (ser_en),
    .ready (tx_ready),
    .data  (ser_byte),
    .last  (ser_last)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        // done high means the previous frame just ended; start is honoured a cycle later.
        if (start && !done) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_nxt = ST_SEL;
      end
      ST_SEL: begin
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = ser_byte;
        if (ser_last) begin
          if (idx == LAST_IDX) begin
`ifdef RF_DUMP_CKSUM_EN
            state_nxt = ST_CKSUM;
`else
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
`endif
          end else begin
            state_nxt = ST_SEL;
          end
        end
      end
`ifdef RF_DUMP_CKSUM_EN
      ST_CKSUM: begin
        tx_valid = 1'b1;
        tx_data  = checksum;
        if (tx_ready) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      reg_sel_q <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (frame_start) begin
        idx <= '0;
      end else if (ser_last && (idx != LAST_IDX)) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_SEL) reg_sel_q <= idx;
    end
  end

`ifdef RF_DUMP_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum <= 8'h00;
    end else if (frame_start) begin
      checksum <= 8'h00;
    end else if (ser_en && tx_ready) begin
      checksum <= checksum ^ ser_byte;
    end
  end
`endif

endmodule

// File: tb/tb_rf_dump_tx.sv
// Bench for rf_dump_tx: randomized rf contents and tx_ready against a queue-based frame model.
// Frame length and trailing byte follow RF_DUMP_CKSUM_EN.
module tb_rf_dump_tx;
  import rf_dump_tx_pkg::*;

`ifdef RF_DUMP_CKSUM_EN
  localparam int FRAME_LEN  = 130;
  localparam int FRAME_CYC  = 163;
`else
  localparam int FRAME_LEN  = 129;
  localparam int FRAME_CYC  = 162;
`endif

  logic        clk = 1'b0;
  logic        rst, start, tx_ready;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;
  logic [31:0] rf [32];

  logic        start2, tx_ready2;
  logic [4:0]  reg_sel2;
  logic [31:0] reg_data2;
  logic [7:0]  tx_data2;
  logic        tx_valid2, busy2, done2;

  always #5 clk = ~clk;

  assign reg_data  = (reg_sel == 5'd0) ? 32'h0 : rf[reg_sel];
  assign reg_data2 = (reg_sel2 == 5'd1) ? 32'hCAFE_F00D : 32'h0;

  rf_dump_tx #(.NREGS(32), .SYNC_BYTE(8'h5A)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_sel(reg_sel), .reg_data(reg_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  rf_dump_tx #(.NREGS(2), .SYNC_BYTE(8'h5A)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .reg_sel(reg_sel2), .reg_data(reg_data2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2), .done(done2)
  );

  int         checks = 0;
  int         errors = 0;
  int         done_cnt;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       lat_valid, lat_busy;
  logic [7:0] lat_data;

  // Reference frame straight from the frame definition: 5A, each register LE, optional XOR.
  function automatic void build_expected();
    logic [31:0] v;
    logic [7:0]  ck;
    exp_q.delete();
    exp_q.push_back(8'h5A);
    ck = 8'h00;
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'h0 : rf[i];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(v[8*b +: 8]);
        ck ^= v[8*b +: 8];
      end
    end
`ifdef RF_DUMP_CKSUM_EN
    exp_q.push_back(ck);
`endif
  endfunction

  function automatic int first_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // One clock: observe outputs, check the hold rule, then drive ready/start for the coming edge.
  task automatic step(input int ready_pct, input bit st, input bit st_on_done);
    @(negedge clk);
    if (prev_stall) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
        errors++;
        $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", tx_valid, tx_data, prev_data);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done: busy=%b required 0", busy);
      end
    end
    tx_ready = (int'($urandom_range(0, 99)) < ready_pct);
    start    = st || (st_on_done && done === 1'b1);
    if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
    prev_stall = (tx_valid === 1'b1) && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic run_frame(input int ready_pct, input int start_at_byte, input bit st_on_done,
                           output int cycles);
    bit fired;
    got.delete();
    done_cnt = 0;
    fired    = 1'b0;
    cycles   = 0;
    step(ready_pct, 1'b1, 1'b0);
    while (done_cnt == 0 && cycles < 5000) begin
      bit s;
      s = (start_at_byte >= 0) && !fired && (got.size() == start_at_byte);
      if (s) fired = 1'b1;
      step(ready_pct, s, st_on_done);
      cycles++;
      if (cycles == 1) begin
        lat_valid = tx_valid;
        lat_data  = tx_data;
        lat_busy  = busy;
      end
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL timeout: done not seen after %0d cycles, bytes=%0d", cycles, got.size());
    end
    repeat (20) step(ready_pct, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string name);
    int d;
    d = first_diff();
    checks++;
    if (got.size() != FRAME_LEN) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes required %0d", name, got.size(), FRAME_LEN);
    end
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s_data: byte %0d got %h required %h", name, d,
               (d < got.size()) ? got[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done: %0d pulses required 1", name, done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; tx_ready = 1'b0; start2 = 1'b0; tx_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00 || reg_sel !== 5'd0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b done=%b data=%h sel=%0d required 0 0 0 00 0",
               tx_valid, busy, done, tx_data, reg_sel);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    build_expected();
    run_frame(100, -1, 1'b1, cyc);
    check_frame("basic");
    checks++;
    if (lat_valid !== 1'b1 || lat_data !== 8'h5A || lat_busy !== 1'b1) begin
      errors++;
      $display("FAIL latency: valid=%b data=%h busy=%b required 1 5a 1", lat_valid, lat_data, lat_busy);
    end
    checks++;
    if (cyc != FRAME_CYC) begin
      errors++;
      $display("FAIL frame_cycles: done at %0d required %0d", cyc, FRAME_CYC);
    end
    checks++;
    if (got.size() >= 9 && {got[5], got[6], got[7], got[8]} !== 32'h0100_0010) begin
      errors++;
      $display("FAIL x1_bytes: got %h%h%h%h required 01000010", got[5], got[6], got[7], got[8]);
    end
    // start was asserted in the done cycle; the drain must have stayed idle.
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_at_done: busy=%b valid=%b required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_random_ready();
    int cyc;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_expected();
    run_frame(50, -1, 1'b0, cyc);
    check_frame("rand_ready");
  endtask

  task automatic test_start_busy();
    int cyc;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_expected();
    run_frame(70, 40, 1'b0, cyc);
    check_frame("start_busy");
  endtask

  task automatic test_reset_mid();
    int cyc;
    int budget;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_expected();
    got.delete();
    done_cnt = 0;
    step(100, 1'b1, 1'b0);
    budget = 0;
    while (got.size() < 30 && budget < 1000) begin
      step(100, 1'b0, 1'b0);
      budget++;
    end
    checks++;
    if (got.size() != 30 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL reach_x7: bytes=%0d valid=%b required 30 1", got.size(), tx_valid);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b required 0 0", tx_valid, busy);
    end
    rst = 1'b1;
    prev_stall = 1'b0;
    @(negedge clk);
    run_frame(100, -1, 1'b0, cyc);
    check_frame("after_reset");
  endtask

  task automatic test_cksum();
    int cyc;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[5] = 32'hDEAD_BEEF;
    build_expected();
    run_frame(100, -1, 1'b0, cyc);
    check_frame("cksum");
`ifdef RF_DUMP_CKSUM_EN
    checks++;
    if (got.size() == 130 && got[129] !== 8'h22) begin
      errors++;
      $display("FAIL cksum_byte: got %h required 22", got[129]);
    end
`endif
  endtask

  task automatic test_nregs2();
    logic [7:0] g2[$];
    logic [7:0] e2[$];
    int         d2;
    e2 = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
`ifdef RF_DUMP_CKSUM_EN
    e2.push_back(8'hC9);
`endif
    d2 = 0;
    @(negedge clk);
    start2 = 1'b1;
    tx_ready2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (tx_valid2 === 1'b1) g2.push_back(tx_data2);
      if (done2 === 1'b1) d2++;
      @(negedge clk);
    end
    checks++;
    if (g2.size() != e2.size()) begin
      errors++;
      $display("FAIL nregs2_len: got %0d bytes required %0d", g2.size(), e2.size());
    end
    for (int i = 0; i < e2.size() && i < g2.size(); i++) begin
      checks++;
      if (g2[i] !== e2[i]) begin
        errors++;
        $display("FAIL nregs2_byte%0d: got %h required %h", i, g2[i], e2[i]);
      end
    end
    checks++;
    if (d2 != 1) begin
      errors++;
      $display("FAIL nregs2_done: %0d pulses required 1", d2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_start_busy();
    test_reset_mid();
    test_cksum();
    test_nregs2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
